tone_mixer: RTL and testbench
=============================

# tone_mixer

Parametrised multi-channel square-wave tone generator for the iceFUN speaker. It replaces the fixed single-frequency beep with CHANNELS independent voices. Each voice is loaded over a valid/ready command port with a half-period and a duration. The active voices are mixed by a first-order sigma-delta modulator into the complementary spkp/spkm speaker drive. It sits behind the PLL clock domain and is fed by a sequencer or CPU register block.

## Interface
- CLK_HZ, 25000000: frequency of clk in Hz.
- TICK_HZ, 1000: duration tick rate; one duration unit = 1/TICK_HZ s.
- CHANNELS, 2: number of voices, 1..8.
- DIV_W, 16: half-period counter width.
- DUR_W, 16: duration counter width.
- clk  in  1  system clock (PLL output).
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted.
- cmd_chan  in  max(1,$clog2(CHANNELS))  target voice.
- cmd_half  in  DIV_W  half-period in clk cycles; 0 = silence (rest).
- cmd_dur  in  DUR_W  length in ticks; 0 = play until replaced.
- busy  out  CHANNELS  voice has a note (or rest) in progress.
- tone  out  CHANNELS  per-voice square wave (debug/test).
- spkp  out  1  mixed speaker drive.
- spkm  out  1  complement of spkp while any voice is sounding.

## Operation
- Tick prescaler:
  - Free-running counter from CLK_HZ/TICK_HZ-1 down to 0.
  - The tick pulse is one cycle at 0.
  - Duration accuracy is therefore -1/+0 tick.
- Per voice: state IDLE or PLAY, plus one pending slot (valid bit, half, dur).
- Handshake:
  - Transfer when cmd_valid && cmd_ready.
  - cmd_ready = !pending_valid[cmd_chan]. This is combinational from cmd_chan.
  - cmd_chan >= CHANNELS: command is accepted and dropped.
- Command to an IDLE voice with empty pending:
  - PLAY starts on the next edge.
  - div = cmd_half-1, phase=0, remaining = cmd_dur.
- Command to a PLAY voice: goes to the pending slot.
  - Exception: if the current note has dur=0 (infinite), the command replaces the current note immediately.
- In PLAY:
  - When div==0: reload div = half-1 and toggle phase. Period = 2*half cycles.
  - half==0: div and phase are held at 0 (rest).
- Note end: on a tick with remaining==1, the note ends.
  - Pending valid: pending is promoted on that same edge. busy stays 1 and there is no gap cycle.
  - Pending empty: voice goes to IDLE and phase is forced to 0.
- tone[i] = phase of voice i, ANDed with PLAY.
- Mixer:
  - s = popcount(tone).
  - acc width is $clog2(CHANNELS)+1.
  - Each cycle: if acc+s >= CHANNELS, then acc <= acc+s-CHANNELS and spkp=1; otherwise acc <= acc+s and spkp=0.
  - Output density = s/CHANNELS.
  - spkm = ~spkp while any busy. When no voice is busy, spkp=spkm=0 and acc=0, so no DC flows across the speaker.
- Simultaneous events: a new command on a voice on the same cycle its note ends is treated as arriving after the end. Its handling follows the post-end pending state.

## Timing
- Reset values (asynchronous):
  - spkp=0, spkm=0, busy=0, tone=0.
  - All pending slots empty, so cmd_ready=1.
  - acc=0, prescaler=CLK_HZ/TICK_HZ-1.
- Reset mid-note: all outputs go to their reset values immediately, with no clock needed, and the note is discarded.
- Command accepted at edge T:
  - busy=1 after T.
  - First phase rise at edge T+half.
- spkp/spkm are registered and lag tone by 1 cycle.

## Structure
- Package tone_pkg holds:
  - Default CLK_HZ/TICK_HZ constants.
  - TICK_DIV = CLK_HZ/TICK_HZ.
  - A note_t struct {half, dur}.
- Sub-module tone_voice, instantiated CHANNELS times in a generate loop, contains:
  - The pending slot.
  - The div counter.
  - Phase.
  - The remaining counter.
  - The IDLE/PLAY FSM.
- The top level holds the prescaler, the command decode and the mixer.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (tick every 10 cycles), CHANNELS=2.
- Reset: assert rst -> spkp=spkm=0, busy=00, tone=00, cmd_ready=1.
- Free-running tone: ch0, half=5, dur=0 -> tone[0] has period 10 cycles with a 5/5 split; spkp alternates 1,0 while tone[0]=1 and is 0 otherwise; spkm=~spkp.
- Duration: ch1, half=3, dur=4 -> busy[1] falls 31..40 cycles after accept, and tone[1]=0 afterwards.
- Pending: ch0 {4,2} then {6,2} while playing -> second accepted, a third on ch0 sees cmd_ready=0, the second starts on the exact edge the first ends, and busy[0] never drops.
- Mixing: both voices half=8 started on the same cycle -> spkp=1 constantly while both tones are high, and 0 while both are low.
- Async reset mid-note: rst pulse between clock edges -> outputs clear before the next edge, and a new command after release plays normally.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared constants and types for the multi-voice tone generator.
package tone_pkg;

  localparam int unsigned DEF_CLK_HZ  = 25_000_000;
  localparam int unsigned DEF_TICK_HZ = 1000;
  localparam int unsigned TICK_DIV    = DEF_CLK_HZ / DEF_TICK_HZ;

  // Wide enough for any supported DIV_W/DUR_W; voices truncate to their own widths.
  localparam int unsigned NOTE_W = 32;

  typedef struct packed {
    logic [NOTE_W-1:0] half;
    logic [NOTE_W-1:0] dur;
  } note_t;

  typedef enum logic {
    V_IDLE,
    V_PLAY
  } voice_state_t;

  function automatic int unsigned tick_div(input int unsigned clk_hz, input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/tone_mixer_if.sv
// Valid/ready command port carrying a voice index, half-period and duration.
interface tone_mixer_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned DUR_W    = 16
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [CH_W-1:0]  cmd_chan;
  logic [DIV_W-1:0] cmd_half;
  logic [DUR_W-1:0] cmd_dur;

  modport master (output cmd_valid, output cmd_chan, output cmd_half, output cmd_dur,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_chan, input  cmd_half, input  cmd_dur,
                  output cmd_ready);
endinterface

// File: rtl/tone_voice.sv
// One square-wave voice: current note, single pending slot, half-period divider
// and tick-based duration counter.
module tone_voice
  import tone_pkg::*;
#(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned DUR_W = 16
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_tick,
  input  logic  i_load,
  input  note_t i_note,
  output logic  o_busy,
  output logic  o_tone,
  output logic  o_pend
);

  voice_state_t     r_state;
  logic [DIV_W-1:0] r_half;
  logic [DIV_W-1:0] r_div;
  logic             r_phase;
  logic [DUR_W-1:0] r_rem;
  logic             r_pend_v;
  logic [DIV_W-1:0] r_pend_half;
  logic [DUR_W-1:0] r_pend_dur;

  logic [DIV_W-1:0] w_half;
  logic [DUR_W-1:0] w_dur;
  logic             w_play;
  logic             w_inf;
  logic             w_end;
  logic             w_start;

  assign w_half = DIV_W'(i_note.half);
  assign w_dur  = DUR_W'(i_note.dur);
  assign w_play = (r_state == V_PLAY);
  // A finite note never lets remaining reach 0, so 0 while playing means infinite.
  assign w_inf  = (r_rem == '0);
  assign w_end  = w_play && i_tick && (r_rem == DUR_W'(1));
  // A load coinciding with a note end sees the voice as already idle.
  assign w_start = i_load && (!w_play || w_end || w_inf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= V_IDLE;
      r_half      <= '0;
      r_div       <= '0;
      r_phase     <= 1'b0;
      r_rem       <= '0;
      r_pend_v    <= 1'b0;
      r_pend_half <= '0;
      r_pend_dur  <= '0;
    end else if (w_start) begin
      r_state <= V_PLAY;
      r_half  <= w_half;
      r_div   <= (w_half == '0) ? '0 : w_half - 1'b1;
      r_phase <= 1'b0;
      r_rem   <= w_dur;
    end else if (w_end) begin
      if (r_pend_v) begin
        r_half   <= r_pend_half;
        r_div    <= (r_pend_half == '0) ? '0 : r_pend_half - 1'b1;
        r_phase  <= 1'b0;
        r_rem    <= r_pend_dur;
        r_pend_v <= 1'b0;
      end else begin
        r_state <= V_IDLE;
        r_div   <= '0;
        r_phase <= 1'b0;
      end
    end else begin
      if (i_load) begin
        r_pend_v    <= 1'b1;
        r_pend_half <= w_half;
        r_pend_dur  <= w_dur;
      end
      if (w_play) begin
        if (r_half == '0) begin
          r_div   <= '0;
          r_phase <= 1'b0;
        end else if (r_div == '0) begin
          r_div   <= r_half - 1'b1;
          r_phase <= ~r_phase;
        end else begin
          r_div <= r_div - 1'b1;
        end
        if (i_tick && !w_inf) r_rem <= r_rem - 1'b1;
      end
    end
  end

  assign o_busy = w_play;
  assign o_tone = r_phase & w_play;
  assign o_pend = r_pend_v;

endmodule

// File: rtl/tone_mixer.sv
// Multi-voice square-wave generator mixed by a first-order sigma-delta
// modulator onto a complementary speaker pair.
module tone_mixer
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ   = DEF_CLK_HZ,
  parameter int unsigned TICK_HZ  = DEF_TICK_HZ,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned DUR_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  tone_mixer_if.slave         cmd,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] tone,
  output logic                spkp,
  output logic                spkm
);

  localparam int unsigned TDIV = tick_div(CLK_HZ, TICK_HZ);
  localparam int unsigned PW   = (TDIV > 1) ? $clog2(TDIV) : 1;
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned AW   = $clog2(CHANNELS) + 1;

  logic [PW-1:0]       r_presc;
  logic                w_tick;
  logic [CHANNELS-1:0] w_pend;
  logic [CHANNELS-1:0] w_load;
  logic                w_ready;
  note_t               w_note;
  logic [AW-1:0]       r_acc;
  logic [AW:0]         w_sum;
  logic                r_spkp;
  logic                r_spkm;

  assign w_tick = (r_presc == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_presc <= PW'(TDIV - 1);
    else     r_presc <= w_tick ? PW'(TDIV - 1) : r_presc - 1'b1;
  end

  // Out-of-range channels match no voice: ready stays high and the command drops.
  always_comb begin
    w_ready = 1'b1;
    w_load  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cmd.cmd_chan == CH_W'(i)) begin
        w_ready   = !w_pend[i];
        w_load[i] = cmd.cmd_valid && !w_pend[i];
      end
    end
  end

  assign cmd.cmd_ready = w_ready;
  assign w_note = '{half: NOTE_W'(cmd.cmd_half), dur: NOTE_W'(cmd.cmd_dur)};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_voice
    tone_voice #(
      .DIV_W(DIV_W),
      .DUR_W(DUR_W)
    ) u_voice (
      .clk    (clk),
      .rst    (rst),
      .i_tick (w_tick),
      .i_load (w_load[g]),
      .i_note (w_note),
      .o_busy (busy[g]),
      .o_tone (tone[g]),
      .o_pend (w_pend[g])
    );
  end

  always_comb begin
    w_sum = {1'b0, r_acc};
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_sum = w_sum + (AW+1)'(tone[i]);
    end
  end

  // Both speaker legs idle low with no voice active so no DC crosses the speaker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_spkp <= 1'b0;
      r_spkm <= 1'b0;
    end else if (!(|busy)) begin
      r_acc  <= '0;
      r_spkp <= 1'b0;
      r_spkm <= 1'b0;
    end else if (w_sum >= (AW+1)'(CHANNELS)) begin
      r_acc  <= AW'(w_sum - (AW+1)'(CHANNELS));
      r_spkp <= 1'b1;
      r_spkm <= 1'b0;
    end else begin
      r_acc  <= AW'(w_sum);
      r_spkp <= 1'b0;
      r_spkm <= 1'b1;
    end
  end

  assign spkp = r_spkp;
  assign spkm = r_spkm;

endmodule

// File: tb/tb_tone_mixer.sv
// Scoreboard bench for tone_mixer: per-edge expectations queued at command time.
module tb_tone_mixer;

  localparam int TDIV = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] busy;
  logic [1:0] tone;
  logic       spkp;
  logic       spkm;

  tone_mixer_if #(.CHANNELS(2), .DIV_W(16), .DUR_W(16)) cmd_if ();

  tone_mixer #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .CHANNELS(2),
    .DIV_W   (16),
    .DUR_W   (16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .cmd  (cmd_if),
    .busy (busy),
    .tone (tone),
    .spkp (spkp),
    .spkm (spkm)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int r0  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         cyc;
    string      tag;
    int         sel;
    logic [1:0] exp;
  } sb_t;

  sb_t        sb[$];
  logic [1:0] e_tone[$];
  logic [1:0] e_busy[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] sel_sig(input int sel);
    case (sel)
      0:       return tone;
      1:       return busy;
      2:       return {1'b0, spkp};
      default: return {1'b0, spkm};
    endcase
  endfunction

  // Monitor: compare every queued expectation due at this edge.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc != cyc) chk({e.tag, "_missed"}, 32'(e.cyc), 32'(cyc));
        else              chk(e.tag, 32'(sel_sig(e.sel)), 32'(e.exp));
      end
    end
  end

  function automatic int next_tick(input int e);
    int m = e + 1;
    while (((m - r0) % TDIV) != 0) m++;
    return m;
  endfunction

  // Entry 0 of e_tone/e_busy is the idle state after edge base; entry k is after base+k.
  task automatic push_run(input string name, input int base);
    int acc = 0;
    int s;
    logic sp, sm;
    for (int k = 1; k < e_tone.size(); k++) begin
      if (e_busy[k-1] == 2'b00) begin
        acc = 0; sp = 1'b0; sm = 1'b0;
      end else begin
        s = acc + int'(e_tone[k-1][0]) + int'(e_tone[k-1][1]);
        if (s >= 2) begin acc = s - 2; sp = 1'b1; end
        else        begin acc = s;     sp = 1'b0; end
        sm = ~sp;
      end
      sb.push_back('{base + k, $sformatf("%s_tone@%0d", name, k), 0, e_tone[k]});
      sb.push_back('{base + k, $sformatf("%s_busy@%0d", name, k), 1, e_busy[k]});
      sb.push_back('{base + k, $sformatf("%s_spkp@%0d", name, k), 2, {1'b0, sp}});
      sb.push_back('{base + k, $sformatf("%s_spkm@%0d", name, k), 3, {1'b0, sm}});
    end
  endtask

  task automatic new_run();
    e_tone.delete();
    e_busy.delete();
    e_tone.push_back(2'b00);
    e_busy.push_back(2'b00);
  endtask

  // Called at a negedge; returns the edge the command is expected on.
  task automatic send(input int ch, input int half, input int dur, output int t_acc);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_chan  = 1'(ch);
    cmd_if.cmd_half  = 16'(half);
    cmd_if.cmd_dur   = 16'(dur);
    t_acc = cyc + 1;
    #1;
    chk($sformatf("ready_ch%0d", ch), 32'(cmd_if.cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && busy != 2'b00; i++) @(negedge clk);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, t2, ta, tb, e1, e2, e4, fall, m, j;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_chan  = '0;
    cmd_if.cmd_half  = '0;
    cmd_if.cmd_dur   = '0;

    // Reset state
    #1 rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_spkp", 32'(spkp), 0);
    chk("rst_spkm", 32'(spkm), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tone", 32'(tone), 0);
    chk("rst_ready", 32'(cmd_if.cmd_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    r0  = cyc;

    // Free-running tone on ch0, half=5
    t = cyc + 1;
    new_run();
    for (j = 0; j < 30; j++) begin
      e_busy.push_back(2'b01);
      e_tone.push_back({1'b0, 1'((j / 5) % 2)});
    end
    push_run("free", t - 1);
    send(0, 5, 0, ta);
    drain("free");
    send(0, 0, 1, ta);
    wait_idle("free");

    // Duration on ch1, half=3 dur=4
    t  = cyc + 1;
    e1 = next_tick(t);
    e4 = next_tick(next_tick(next_tick(e1)));
    new_run();
    for (m = t; m <= e4 + 2; m++) begin
      j = m - t;
      e_busy.push_back((m < e4) ? 2'b10 : 2'b00);
      e_tone.push_back((m < e4) ? {1'((j / 3) % 2), 1'b0} : 2'b00);
    end
    push_run("dur", t - 1);
    send(1, 3, 4, ta);
    fall = -1;
    for (int i = 0; i < 60 && fall < 0; i++) begin
      @(negedge clk);
      if (busy[1] == 1'b0) fall = cyc - ta;
    end
    chk("dur_window", 32'(fall >= 31 && fall <= 40), 1);
    drain("dur");

    // Pending slot on ch0: {4,2} then {6,2}
    t  = cyc + 1;
    e1 = next_tick(t);
    e2 = next_tick(e1);
    e4 = next_tick(next_tick(e2));
    new_run();
    for (m = t; m <= e4 + 3; m++) begin
      e_busy.push_back((m < e4) ? 2'b01 : 2'b00);
      if (m < e2)      e_tone.push_back({1'b0, 1'(((m - t) / 4) % 2)});
      else if (m < e4) e_tone.push_back({1'b0, 1'(((m - e2) / 6) % 2)});
      else             e_tone.push_back(2'b00);
    end
    push_run("pend", t - 1);
    send(0, 4, 2, ta);
    send(0, 6, 2, tb);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_chan  = 1'b0;
    cmd_if.cmd_half  = 16'd1;
    cmd_if.cmd_dur   = 16'd1;
    #1;
    chk("pend_ready_low", 32'(cmd_if.cmd_ready), 0);
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    drain("pend");
    #1;
    chk("pend_ready_back", 32'(cmd_if.cmd_ready), 1);
    wait_idle("pend");

    // Mixing: both voices promoted from a rest on the same tick edge
    while (((cyc - r0) % TDIV) != 0) @(negedge clk);
    t  = cyc + 1;
    e1 = next_tick(t);
    new_run();
    for (m = t; m <= e1 + 40; m++) begin
      e_busy.push_back((m == t) ? 2'b01 : 2'b11);
      e_tone.push_back((m >= e1 && (((m - e1) / 8) % 2) == 1) ? 2'b11 : 2'b00);
    end
    push_run("mix", t - 1);
    send(0, 0, 1, ta);
    send(1, 0, 1, ta);
    send(0, 8, 0, ta);
    send(1, 8, 0, ta);
    drain("mix");
    send(0, 0, 1, ta);
    send(1, 0, 1, ta);
    wait_idle("mix");

    // Asynchronous reset mid-note, then a fresh note
    send(0, 5, 0, t);
    repeat (6) @(negedge clk);
    chk("arst_pre_tone", 32'(tone), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_tone", 32'(tone), 0);
    chk("arst_spkp", 32'(spkp), 0);
    chk("arst_spkm", 32'(spkm), 0);
    chk("arst_ready", 32'(cmd_if.cmd_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    r0  = cyc;
    t2  = cyc + 1;
    new_run();
    for (j = 0; j < 16; j++) begin
      e_busy.push_back(2'b10);
      e_tone.push_back({1'((j / 3) % 2), 1'b0});
    end
    push_run("post", t2 - 1);
    send(1, 3, 0, ta);
    drain("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
